// File: rtl/jzjpcc_muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : jzjpcc_muldiv_sequencer_if
// Brief    : Execute-stage handshake bundle for the RV32M multiply/divide unit.
// Revision : 1.0
// ============================================================================
interface jzjpcc_muldiv_sequencer_if;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic        flush;
   logic        busy;
   logic        stall;
   logic        resultValid;
   logic [31:0] result;

   modport master (
      output start, funct3, operandA, operandB, flush,
      input  busy, stall, resultValid, result
   );

   modport slave (
      input  start, funct3, operandA, operandB, flush,
      output busy, stall, resultValid, result
   );
endinterface
`default_nettype wire

// File: rtl/jzjpcc_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : jzjpcc_muldiv_sequencer
// Brief    : RV32M sequencer: 32-step shift-add multiply / restoring divide.
//            Define JZJPCC_MUL_SINGLE_CYCLE_EN for a one-cycle multiplier.
// Revision : 1.0
// ============================================================================
module jzjpcc_muldiv_sequencer (
   input  wire logic                  clock,
   input  wire logic                  reset,
   jzjpcc_muldiv_sequencer_if.slave   bus
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_mul  = 2'd1;
   localparam logic [1:0] c_div  = 2'd2;
   localparam logic [1:0] c_done = 2'd3;

   logic [1:0]  r_state;
   logic        r_busy;
   logic        r_valid;
   logic [31:0] r_result;
   logic [4:0]  r_count;
   logic [1:0]  r_sel;
   logic [31:0] r_mag_a;
   logic [31:0] r_mag_b;
   logic        r_neg;
   logic [63:0] r_prod;
   logic [31:0] r_rem;
   logic [31:0] r_quo;

   logic [2:0]  w_f3;
   logic        w_a_signed;
   logic        w_b_signed;
   logic        w_sa;
   logic        w_sb;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic        w_neg;
   logic        w_div_zero;
   logic        w_ovf;
   logic [31:0] w_special;
   logic        w_ready;

   assign w_f3       = bus.funct3;
   assign w_a_signed = (w_f3 != 3'b011) && (w_f3 != 3'b101) && (w_f3 != 3'b111);
   assign w_b_signed = w_a_signed && (w_f3 != 3'b010);
   assign w_sa       = w_a_signed & bus.operandA[31];
   assign w_sb       = w_b_signed & bus.operandB[31];
   assign w_mag_a    = w_sa ? -bus.operandA : bus.operandA;
   assign w_mag_b    = w_sb ? -bus.operandB : bus.operandB;
   // Remainders take the dividend's sign; products and quotients the XOR.
   assign w_neg      = (w_f3[2] & w_f3[1]) ? w_sa : (w_sa ^ w_sb);
   assign w_div_zero = (bus.operandB == 32'd0);
   assign w_ovf      = w_f3[2] & ~w_f3[0] & (bus.operandA == 32'h8000_0000) &
                       (bus.operandB == 32'hFFFF_FFFF);
   assign w_special  = w_div_zero ? (w_f3[1] ? bus.operandA : 32'hFFFF_FFFF)
                                  : (w_f3[1] ? 32'd0 : 32'h8000_0000);
   assign w_ready    = (r_state == c_idle) || (r_state == c_done);

   // Shift-add step: low half of r_prod holds the remaining multiplier bits.
   logic [32:0] w_sum;
   logic [63:0] w_prod_nxt;
   logic [63:0] w_prod_fin;
   logic [31:0] w_mul_res;
   assign w_sum      = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mag_a} : 33'd0);
   assign w_prod_nxt = {w_sum, r_prod[31:1]};
   assign w_prod_fin = r_neg ? -w_prod_nxt : w_prod_nxt;
   assign w_mul_res  = (r_sel == 2'b00) ? w_prod_fin[31:0] : w_prod_fin[63:32];

   // Restoring step: dividend bits are shifted out of r_quo as quotient bits enter.
   logic [32:0] w_shift;
   logic [32:0] w_trial;
   logic [31:0] w_rem_nxt;
   logic [31:0] w_quo_nxt;
   logic [31:0] w_div_raw;
   logic [31:0] w_div_res;
   assign w_shift   = {r_rem, r_quo[31]};
   assign w_trial   = w_shift - {1'b0, r_mag_b};
   assign w_rem_nxt = w_trial[32] ? w_shift[31:0] : w_trial[31:0];
   assign w_quo_nxt = {r_quo[30:0], ~w_trial[32]};
   assign w_div_raw = r_sel[1] ? w_rem_nxt : w_quo_nxt;
   assign w_div_res = r_neg ? -w_div_raw : w_div_raw;

`ifdef JZJPCC_MUL_SINGLE_CYCLE_EN
   logic [63:0] w_prod_full;
   logic [63:0] w_prod_fast;
   logic [31:0] w_fast_res;
   assign w_prod_full = {32'd0, w_mag_a} * {32'd0, w_mag_b};
   assign w_prod_fast = w_neg ? -w_prod_full : w_prod_full;
   assign w_fast_res  = (w_f3[1:0] == 2'b00) ? w_prod_fast[31:0] : w_prod_fast[63:32];
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= c_idle;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
         r_result <= 32'd0;
         r_count  <= 5'd0;
         r_sel    <= 2'b00;
         r_mag_a  <= 32'd0;
         r_mag_b  <= 32'd0;
         r_neg    <= 1'b0;
         r_prod   <= 64'd0;
         r_rem    <= 32'd0;
         r_quo    <= 32'd0;
      end else if (bus.flush) begin
         r_state <= c_idle;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_count <= 5'd0;
      end else begin
         case (r_state)
            c_mul: begin
               r_prod  <= w_prod_nxt;
               r_count <= r_count + 5'd1;
               if (r_count == 5'd31) begin
                  r_state  <= c_done;
                  r_busy   <= 1'b0;
                  r_valid  <= 1'b1;
                  r_result <= w_mul_res;
               end
            end
            c_div: begin
               r_rem   <= w_rem_nxt;
               r_quo   <= w_quo_nxt;
               r_count <= r_count + 5'd1;
               if (r_count == 5'd31) begin
                  r_state  <= c_done;
                  r_busy   <= 1'b0;
                  r_valid  <= 1'b1;
                  r_result <= w_div_res;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= c_idle;
               if (bus.start) begin
                  r_sel   <= w_f3[1:0];
                  r_mag_a <= w_mag_a;
                  r_mag_b <= w_mag_b;
                  r_neg   <= w_neg;
                  r_count <= 5'd0;
                  if (!w_f3[2]) begin
`ifdef JZJPCC_MUL_SINGLE_CYCLE_EN
                     r_state  <= c_done;
                     r_valid  <= 1'b1;
                     r_result <= w_fast_res;
`else
                     r_state <= c_mul;
                     r_busy  <= 1'b1;
                     r_prod  <= {32'd0, w_mag_b};
`endif
                  end else if (w_div_zero || w_ovf) begin
                     r_state  <= c_done;
                     r_valid  <= 1'b1;
                     r_result <= w_special;
                  end else begin
                     r_state <= c_div;
                     r_busy  <= 1'b1;
                     r_rem   <= 32'd0;
                     r_quo   <= w_mag_a;
                  end
               end
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.stall       = (bus.start & w_ready) | r_busy;
   assign bus.resultValid = r_valid;
   assign bus.result      = r_result;

endmodule
`default_nettype wire

// File: tb/tb_jzjpcc_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jzjpcc_muldiv_sequencer
// Brief    : Directed self-checking bench with an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_jzjpcc_muldiv_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jzjpcc_muldiv_sequencer_if bus ();

   jzjpcc_muldiv_sequencer dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   typedef struct {
      int          cyc;
      logic [31:0] val;
      logic [31:0] lit;
   } exp_t;

   exp_t q[$];
   int   cyc        = 0;
   int   npass      = 0;
   int   ntot       = 0;
   int   busy_lo    = 1;
   int   busy_hi    = 0;
   int   zero_at    = -1;
   int   last_issue = 0;
   int   last_valid = 0;
   logic chk_on     = 1'b0;
   logic [31:0] hold = 32'd0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntot = ntot + 1;
      if (act === exp) npass = npass + 1;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      logic [63:0] r;
      logic [31:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      res = 32'd0;
      case (f)
         3'b000: begin p = sa * sb; r = 64'(p); res = r[31:0];  end
         3'b001: begin p = sa * sb; r = 64'(p); res = r[63:32]; end
         3'b010: begin p = sa * ub; r = 64'(p); res = r[63:32]; end
         3'b011: begin p = ua * ub; r = 64'(p); res = r[63:32]; end
         3'b100: begin
            if (b == 32'd0) res = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
            else begin p = sa / sb; r = 64'(p); res = r[31:0]; end
         end
         3'b101: begin
            if (b == 32'd0) res = 32'hFFFF_FFFF;
            else begin p = ua / ub; r = 64'(p); res = r[31:0]; end
         end
         3'b110: begin
            if (b == 32'd0) res = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
            else begin p = sa % sb; r = 64'(p); res = r[31:0]; end
         end
         default: begin
            if (b == 32'd0) res = a;
            else begin p = ua % ub; r = 64'(p); res = r[31:0]; end
         end
      endcase
      return res;
   endfunction

   function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2]) begin
`ifdef JZJPCC_MUL_SINGLE_CYCLE_EN
         return 1;
`else
         return 33;
`endif
      end
      if (b == 32'd0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Per-cycle comparison of every output against the model's expectations.
   always @(negedge clk) begin
      if (chk_on) begin
         logic exp_v;
         logic exp_b;
         if (zero_at == cyc) hold = 32'd0;
         while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
         exp_v = (q.size() > 0) && (q[0].cyc == cyc);
         exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
         check("resultValid", {31'd0, bus.resultValid}, {31'd0, exp_v});
         if (exp_v) begin
            check("result_model", bus.result, q[0].val);
            check("result_literal", bus.result, q[0].lit);
            hold = q[0].val;
            void'(q.pop_front());
         end else begin
            check("result_hold", bus.result, hold);
         end
         check("busy", {31'd0, bus.busy}, {31'd0, exp_b});
         check("stall", {31'd0, bus.stall}, {31'd0, bus.start | exp_b});
      end
   end

   task automatic wait_cyc(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit);
      exp_t e;
      int   lat;
      @(posedge clk); #2;
      bus.start    = 1'b1;
      bus.funct3   = f;
      bus.operandA = a;
      bus.operandB = b;
      lat        = latency(f, a, b);
      last_issue = cyc;
      e.cyc      = cyc + lat;
      e.val      = model(f, a, b);
      e.lit      = lit;
      last_valid = e.cyc;
      q.push_back(e);
      if (lat > 1) begin
         busy_lo = cyc + 1;
         busy_hi = cyc + lat - 1;
      end
      @(posedge clk); #2;
      bus.start = 1'b0;
   endtask

   task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] lit);
      issue(f, a, b, lit);
      wait_cyc(last_valid + 1);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.funct3   = 3'b000;
      bus.operandA = 32'd0;
      bus.operandB = 32'd0;
      bus.flush    = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst    = 1'b0;
      chk_on = 1'b1;
      repeat (2) @(posedge clk);

      // Back-to-back: the remu is launched in the DONE cycle of the divu.
      issue(3'b101, 32'd100, 32'd7, 32'd14);
      wait_cyc(last_valid - 1);
      issue(3'b111, 32'd100, 32'd7, 32'd2);
      wait_cyc(last_valid + 1);

      run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      run(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1);
      run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
      run(3'b110, 32'h1234_5678, 32'd0, 32'h1234_5678);
      run(3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
      run(3'b111, 32'd9, 32'd0, 32'd9);
      run(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

      run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(3'b000, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4);
      run(3'b000, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001);

      // A second start while busy must not disturb the running divide.
      issue(3'b101, 32'd1000, 32'd10, 32'd100);
      wait_cyc(last_issue + 4);
      @(posedge clk); #2;
      bus.start    = 1'b1;
      bus.funct3   = 3'b101;
      bus.operandA = 32'd7;
      bus.operandB = 32'd0;
      @(posedge clk); #2;
      bus.start = 1'b0;
      wait_cyc(last_valid + 1);

      // Flush in cycle k+10 squashes the op.
      issue(3'b100, 32'd50, 32'd5, 32'd10);
      wait_cyc(last_issue + 9);
      @(posedge clk); #2;
      bus.flush = 1'b1;
      q.delete();
      busy_hi = cyc;
      @(posedge clk); #2;
      bus.flush = 1'b0;
      wait_cyc(last_issue + 40);

      // Two-cycle reset mid-divide.
      issue(3'b101, 32'd1234, 32'd3, 32'd411);
      wait_cyc(last_issue + 14);
      @(posedge clk); #2;
      rst = 1'b1;
      q.delete();
      busy_hi = cyc;
      zero_at = cyc + 1;
      @(posedge clk); #2;
      @(posedge clk); #2;
      rst = 1'b0;
      wait_cyc(cyc + 5);

      run(3'b101, 32'd1234, 32'd3, 32'd411);
      repeat (3) @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
`default_nettype wire
